// File: rtl/thermal_overlay_if.sv
// thermal_overlay_if: frame-buffer read port (address out, data back one cycle later)
interface thermal_overlay_if #(parameter int p_addrw = 10);
  logic rd_valid;
  logic [p_addrw-1:0] rd_addr;
  logic [7:0] rd_data;
  modport master(output rd_valid, rd_addr, input rd_data);
  modport slave(input rd_valid, rd_addr, output rd_data);
endinterface

// File: rtl/thermal_overlay.sv
// thermal_overlay: reads the thermal frame buffer, false-colours it and composites
// the upscaled window over camera video with all outputs delay-matched to 4 cycles.
module thermal_overlay #(
  parameter int p_scale_shift = 3,
  parameter int p_cols = 32,
  parameter int p_rows = 24,
  parameter int p_addrw = 10
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_hsync,
  input  logic i_vsync,
  input  logic i_de,
  input  logic signed [15:0] i_x_pos,
  input  logic signed [15:0] i_y_pos,
  input  logic [2:0][7:0] i_cam_data,
  input  logic i_mode_next,
  thermal_overlay_if.master fb,
  output logic o_hsync,
  output logic o_vsync,
  output logic o_de,
  output logic [2:0][7:0] o_data,
  output logic [1:0] o_mode
);
  logic [31:0] cx, cy;
  logic in_win, boundary, acc_en;
  logic rd_valid_q, rd_valid_d;
  logic [p_addrw-1:0] rd_addr_q, rd_addr_d;
  logic [3:0] hs_q, hs_d, vs_q, vs_d, de_q, de_d, win_q, win_d;
  logic [3:0][23:0] cam_q, cam_d;
  logic vs_prev_q, vs_prev_d, pend_q, pend_d;
  logic [7:0] acc_min_q, acc_min_d, acc_max_q, acc_max_d, min_r_q, min_r_d;
  logic [2:0] sh_r_q, sh_r_d, msb;
  logic [1:0] mode_q, mode_d;
  logic [7:0] v_q, v_d, span, k;
  logic [15:0] diff;
  logic [23:0] pal, data_q, data_d;
  always_comb begin
    cx = {16'd0, i_x_pos} >> p_scale_shift;
    cy = {16'd0, i_y_pos} >> p_scale_shift;
    in_win = !i_x_pos[15] && !i_y_pos[15] && cx < 32'(p_cols) && cy < 32'(p_rows);
    rd_valid_d = in_win;
    rd_addr_d = in_win ? p_addrw'(cy * 32'(p_cols) + cx) : '0;
    hs_d = {hs_q[2:0], i_hsync};
    vs_d = {vs_q[2:0], i_vsync};
    de_d = {de_q[2:0], i_de};
    win_d = {win_q[2:0], in_win};
    cam_d = {cam_q[2:0], i_cam_data};
    vs_prev_d = i_vsync;
    boundary = i_vsync && !vs_prev_q;
    // RAM data for a sample lines up with stage 1 of the delay line
    acc_en = win_q[1] && de_q[1];
    span = acc_max_q - acc_min_q;
    msb = '0;
    for (int i = 1; i < 8; i++) msb = span[i] ? 3'(i) : msb;
    acc_min_d = boundary ? 8'd255 : (acc_en && fb.rd_data < acc_min_q) ? fb.rd_data : acc_min_q;
    acc_max_d = boundary ? 8'd0 : (acc_en && fb.rd_data > acc_max_q) ? fb.rd_data : acc_max_q;
    min_r_d = (boundary && acc_max_q >= acc_min_q) ? acc_min_q : min_r_q;
    sh_r_d = (boundary && acc_max_q >= acc_min_q) ? 3'd7 - msb : sh_r_q;
    pend_d = i_mode_next || (pend_q && !boundary);
    mode_d = (boundary && pend_q) ? mode_q + 2'd1 : mode_q;
    diff = {8'd0, fb.rd_data - min_r_q} << sh_r_q;
    v_d = mode_q != 2'd3 ? fb.rd_data : fb.rd_data < min_r_q ? 8'd0 : |diff[15:8] ? 8'd255 : diff[7:0];
    k = {v_q[5:0], 2'b00};
    pal = v_q < 8'd64 ? {k, 16'd0} : v_q < 8'd128 ? {8'd252 - k, 8'd0, k} :
          v_q < 8'd192 ? {8'd0, k, 8'd255} : {k, 16'hFFFF};
    data_d = !de_q[2] ? 24'd0 : (win_q[2] && mode_q != 2'd0) ? (mode_q == 2'd1 ? {3{v_q}} : pal) : cam_q[2];
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd_valid_q <= 1'b0;
      rd_addr_q <= '0;
      hs_q <= '0;
      vs_q <= '0;
      de_q <= '0;
      win_q <= '0;
      cam_q <= '0;
      vs_prev_q <= 1'b0;
      pend_q <= 1'b0;
      acc_min_q <= 8'd255;
      acc_max_q <= 8'd0;
      min_r_q <= 8'd0;
      sh_r_q <= 3'd0;
      mode_q <= 2'd0;
      v_q <= 8'd0;
      data_q <= 24'd0;
    end else begin
      rd_valid_q <= rd_valid_d;
      rd_addr_q <= rd_addr_d;
      hs_q <= hs_d;
      vs_q <= vs_d;
      de_q <= de_d;
      win_q <= win_d;
      cam_q <= cam_d;
      vs_prev_q <= vs_prev_d;
      pend_q <= pend_d;
      acc_min_q <= acc_min_d;
      acc_max_q <= acc_max_d;
      min_r_q <= min_r_d;
      sh_r_q <= sh_r_d;
      mode_q <= mode_d;
      v_q <= v_d;
      data_q <= data_d;
    end
  end
  assign fb.rd_valid = rd_valid_q;
  assign fb.rd_addr = rd_addr_q;
  assign o_hsync = hs_q[3];
  assign o_vsync = vs_q[3];
  assign o_de = de_q[3];
  assign o_data = data_q;
  assign o_mode = mode_q;
endmodule

// File: tb/tb_thermal_overlay.sv
// tb_thermal_overlay: scoreboard bench for thermal_overlay with a 1-cycle-latency RAM model
module tb_thermal_overlay;
  logic i_clk = 1'b0, i_rst = 1'b1;
  logic i_hsync = 1'b0, i_vsync = 1'b0, i_de = 1'b0, i_mode_next = 1'b0;
  logic signed [15:0] i_x_pos = '0, i_y_pos = '0;
  logic [2:0][7:0] i_cam_data = '0;
  logic o_hsync, o_vsync, o_de;
  logic [2:0][7:0] o_data;
  logic [1:0] o_mode;
  thermal_overlay_if #(.p_addrw(10)) fb();
  thermal_overlay dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_hsync(i_hsync), .i_vsync(i_vsync), .i_de(i_de),
    .i_x_pos(i_x_pos), .i_y_pos(i_y_pos), .i_cam_data(i_cam_data), .i_mode_next(i_mode_next),
    .fb(fb), .o_hsync(o_hsync), .o_vsync(o_vsync), .o_de(o_de), .o_data(o_data), .o_mode(o_mode)
  );
  always #20 i_clk = ~i_clk;
  logic [7:0] mem [1024];
  always @(posedge i_clk) fb.rd_data <= mem[fb.rd_addr];
  typedef struct { logic [23:0] data; logic hs, vs, de; } exp_t;
  exp_t sb[$];
  int errs = 0, checks = 0;
  int exp_mode = 0;
  bit pend = 0, pvs = 0, mchk = 0, achk = 0, rst_req = 1;
  logic a_v;
  logic [9:0] a_a;
  string a_tag;
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [23:0] rgb(int r, int g, int b);
    return {8'(b), 8'(g), 8'(r)};
  endfunction
  task automatic tick(int x, int y, logic vs, logic de, logic mn, logic [23:0] cam, logic [23:0] exp);
    exp_t e;
    bit w;
    @(negedge i_clk);
    if (achk) begin
      chk({a_tag, "_valid"}, 32'(fb.rd_valid), 32'(a_v));
      chk({a_tag, "_addr"}, 32'(fb.rd_addr), 32'(a_a));
    end
    if (mchk) chk("mode", 32'(o_mode), 32'(exp_mode));
    if (sb.size() == 4) begin
      e = sb.pop_front();
      chk("data", 32'(o_data), 32'(e.data));
      chk("sync", {29'd0, o_hsync, o_vsync, o_de}, {29'd0, e.hs, e.vs, e.de});
    end
    i_rst = rst_req;
    i_x_pos = 16'(x);
    i_y_pos = 16'(y);
    i_hsync = x[3];
    i_vsync = vs;
    i_de = de;
    i_mode_next = mn;
    i_cam_data = cam;
    w = x >= 0 && y >= 0 && (x >> 3) < 32 && (y >> 3) < 24;
    a_tag = "addr";
    achk = 1;
    mchk = 1;
    if (rst_req) begin
      foreach (sb[i]) sb[i] = '{24'd0, 1'b0, 1'b0, 1'b0};
      e = '{24'd0, 1'b0, 1'b0, 1'b0};
      a_v = 1'b0;
      a_a = '0;
      exp_mode = 0;
      pend = 0;
      pvs = 0;
    end else begin
      e = '{exp, x[3], vs, de};
      a_v = w;
      a_a = w ? 10'((y >> 3) * 32 + (x >> 3)) : '0;
      if (vs && !pvs) begin
        if (pend) exp_mode = (exp_mode + 1) % 4;
        pend = mn;
      end else pend = pend | mn;
      pvs = vs;
    end
    sb.push_back(e);
  endtask
  task automatic idle(logic vs, logic mn);
    tick(-50, -50, vs, 1'b0, mn, 24'hABCDEF, 24'd0);
  endtask
  task automatic flush();
    repeat (4) idle(1'b0, 1'b0);
  endtask
  task automatic frame_end(logic mn_on_edge);
    idle(1'b1, mn_on_edge);
    idle(1'b1, 1'b0);
    idle(1'b0, 1'b0);
    idle(1'b0, 1'b0);
  endtask
  initial begin
    logic [23:0] cam;
    for (int i = 0; i < 1024; i++) mem[i] = 8'h60;
    mem[0] = 8'd5;
    mem[2] = 8'd77;
    mem[10] = 8'd0; mem[11] = 8'd100; mem[12] = 8'd128; mem[13] = 8'd255;
    mem[14] = 8'd64; mem[15] = 8'd192;
    mem[20] = 8'd40; mem[21] = 8'd55; mem[22] = 8'd72;
    mem[23] = 8'd50; mem[24] = 8'd30; mem[25] = 8'd200; mem[26] = 8'd40; mem[27] = 8'd103;
    mem[30] = 8'd90; mem[31] = 8'd91;
    repeat (3) idle(1'b0, 1'b0);
    rst_req = 0;
    // mode 0: camera passthrough across the right window edge
    for (int i = 0; i < 12; i++) begin
      cam = 24'(i * 24'h010203 + 24'h102030);
      tick(250 + i, 0, 1'b0, 1'b1, 1'b0, cam, cam);
    end
    tick(255, 191, 1'b0, 1'b1, 1'b0, 24'h111111, 24'h111111);
    a_tag = "c255_191"; a_v = 1'b1; a_a = 10'd767;
    tick(8, 8, 1'b0, 1'b1, 1'b0, 24'h222222, 24'h222222);
    a_tag = "c8_8"; a_v = 1'b1; a_a = 10'd33;
    tick(256, 0, 1'b0, 1'b1, 1'b0, 24'h333333, 24'h333333);
    a_tag = "c256_0"; a_v = 1'b0; a_a = 10'd0;
    tick(-1, 0, 1'b0, 1'b1, 1'b0, 24'h444444, 24'h444444);
    a_tag = "cm1_0"; a_v = 1'b0; a_a = 10'd0;
    tick(0, 192, 1'b0, 1'b1, 1'b0, 24'h555555, 24'h555555);
    flush();
    // three pulses in one frame give one increment, only at the vsync edge
    idle(1'b0, 1'b1); idle(1'b0, 1'b0); idle(1'b0, 1'b1); idle(1'b0, 1'b1); idle(1'b0, 1'b0);
    chk("pre_vs_mode", 32'(o_mode), 32'd0);
    frame_end(1'b0);
    chk("multi_pulse_mode", 32'(o_mode), 32'd1);
    // mode 1: grey
    tick(16, 0, 1'b0, 1'b1, 1'b0, 24'h010101, rgb(77, 77, 77));
    tick(300, 0, 1'b0, 1'b1, 1'b0, 24'h0A0B0C, 24'h0A0B0C);
    flush();
    idle(1'b0, 1'b1);
    frame_end(1'b0);
    chk("mode2", 32'(o_mode), 32'd2);
    // mode 2: fixed-range ironbow
    tick(80, 0, 1'b0, 1'b1, 1'b0, 24'h777777, rgb(0, 0, 0));
    tick(88, 0, 1'b0, 1'b1, 1'b0, 24'h777777, rgb(144, 0, 108));
    tick(96, 0, 1'b0, 1'b1, 1'b0, 24'h777777, rgb(255, 0, 0));
    tick(104, 0, 1'b0, 1'b1, 1'b0, 24'h777777, rgb(255, 255, 252));
    tick(112, 0, 1'b0, 1'b1, 1'b0, 24'h777777, rgb(0, 0, 252));
    tick(120, 0, 1'b0, 1'b1, 1'b0, 24'h777777, rgb(255, 255, 0));
    tick(104, 0, 1'b0, 1'b0, 1'b0, 24'h777777, 24'd0);
    tick(300, 0, 1'b0, 1'b1, 1'b0, 24'h123456, 24'h123456);
    flush();
    frame_end(1'b0);
    // calibration frame, samples 40..72: span 32 gives shift 2
    tick(160, 0, 1'b0, 1'b1, 1'b0, 24'h0, rgb(0, 0, 160));
    tick(168, 0, 1'b0, 1'b1, 1'b0, 24'h0, rgb(0, 0, 220));
    tick(176, 0, 1'b0, 1'b1, 1'b0, 24'h0, rgb(32, 0, 220));
    idle(1'b0, 1'b1);
    flush();
    frame_end(1'b0);
    chk("mode3", 32'(o_mode), 32'd3);
    // frame without in-window de must keep the previous range
    tick(0, 0, 1'b0, 1'b0, 1'b0, 24'h999999, 24'd0);
    tick(400, 10, 1'b0, 1'b1, 1'b0, 24'h0F0F0F, 24'h0F0F0F);
    flush();
    frame_end(1'b0);
    tick(184, 0, 1'b0, 1'b1, 1'b0, 24'h0, rgb(0, 0, 160));
    tick(192, 0, 1'b0, 1'b1, 1'b0, 24'h0, rgb(0, 0, 0));
    tick(200, 0, 1'b0, 1'b1, 1'b0, 24'h0, rgb(255, 255, 252));
    tick(208, 0, 1'b0, 1'b1, 1'b0, 24'h0, rgb(0, 0, 0));
    tick(216, 0, 1'b0, 1'b1, 1'b0, 24'h0, rgb(255, 255, 240));
    flush();
    // pulse on the boundary cycle is deferred one frame
    frame_end(1'b1);
    chk("coinc_hold", 32'(o_mode), 32'd3);
    frame_end(1'b0);
    chk("coinc_apply", 32'(o_mode), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      idle(1'b0, 1'b1);
      frame_end(1'b0);
      chk("step_mode", 32'(o_mode), 32'(i % 4));
    end
    // reset mid-line while in mode 1
    idle(1'b0, 1'b1);
    frame_end(1'b0);
    tick(240, 0, 1'b0, 1'b1, 1'b0, 24'h0, rgb(90, 90, 90));
    tick(248, 0, 1'b0, 1'b1, 1'b0, 24'h0, rgb(91, 91, 91));
    rst_req = 1;
    tick(232, 0, 1'b0, 1'b1, 1'b0, 24'h0, 24'd0);
    rst_req = 0;
    for (int i = 0; i < 6; i++) begin
      cam = 24'(i * 24'h0A0B0C + 24'h010203);
      tick(i * 8, 0, 1'b0, 1'b1, 1'b0, cam, cam);
      if (i == 0) chk("rst_mode", 32'(o_mode), 32'd0);
    end
    flush();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
